// File: rtl/imem_fetch_port.sv
// rtl/imem_fetch_port.sv - icache miss responder: four pipelined byte reads assembled into a little-endian word; optional next-word prefetch under IMEM_NEXT_WORD_PREFETCH_EN

module imem_fetch_port #(
    parameter int RAM_LAT = 1,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic [ADDR_W-1:0] Mc_addr,
    input  logic              Mc_addr_sgn,
    output logic [31:0]       MC_val,
    output logic              MC_val_sgn,
    input  logic [7:0]        mem_din,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    // cnt = k while the cycle after edge E(k) is running; byte b arrives when cnt = b + RAM_LAT
    localparam logic [2:0] LAT_C   = 3'(RAM_LAT);
    localparam logic [2:0] FINAL_C = 3'(RAM_LAT + 3);

    state_t            state;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] base;
    logic [23:0]       asm_q;

    logic [ADDR_W-1:0] req_a;
    logic [ADDR_W-1:0] next_a;
    logic [2:0]        cap_sel;
    logic              cap_en;
    logic              last_cap;
    logic [31:0]       word;
    logic              unused_addr_lsbs;

`ifdef IMEM_NEXT_WORD_PREFETCH_EN
    logic              pf_run;
    logic              pf_pending;
    logic              pf_valid;
    logic [ADDR_W-1:0] pf_addr;
    logic [31:0]       pf_data;
    logic              pf_hit;
    logic              pf_same;

    assign pf_hit  = pf_valid && (pf_addr == req_a);
    assign pf_same = Mc_addr_sgn && (req_a == base);
`endif

    assign req_a            = {Mc_addr[ADDR_W-1:2], 2'b00};
    assign unused_addr_lsbs = ^Mc_addr[1:0];
    assign next_a           = base + {{(ADDR_W-3){1'b0}}, cnt + 3'd1};
    assign cap_sel          = cnt - LAT_C;
    assign cap_en           = (cnt >= LAT_C) && (cap_sel < 3'd3);
    assign last_cap         = (cnt == FINAL_C);
    assign word             = {mem_din, asm_q};

    assign mem_wr = 1'b0;
    assign busy   = (state != IDLE);

    // Fetch sequencer: request sampling, byte issue and capture, response pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            base       <= '0;
            asm_q      <= '0;
            mem_a      <= '0;
            MC_val     <= '0;
            MC_val_sgn <= 1'b0;
`ifdef IMEM_NEXT_WORD_PREFETCH_EN
            pf_run     <= 1'b0;
            pf_pending <= 1'b0;
            pf_valid   <= 1'b0;
            pf_addr    <= '0;
            pf_data    <= '0;
`endif
        end else if (rollback) begin
            // flush wins over a new request, completion and stall; partial bytes dropped
            state      <= IDLE;
            cnt        <= '0;
            asm_q      <= '0;
            MC_val_sgn <= 1'b0;
`ifdef IMEM_NEXT_WORD_PREFETCH_EN
            pf_run     <= 1'b0;
            pf_pending <= 1'b0;
`endif
        end else if (rdy) begin
            case (state)
                IDLE: begin
`ifdef IMEM_NEXT_WORD_PREFETCH_EN
                    if (Mc_addr_sgn && pf_hit) begin
                        base       <= pf_addr;
                        MC_val     <= pf_data;
                        MC_val_sgn <= 1'b1;
                        pf_valid   <= 1'b0;
                        pf_pending <= 1'b0;
                        state      <= RESP;
                    end else if (Mc_addr_sgn) begin
                        base       <= req_a;
                        mem_a      <= req_a;
                        cnt        <= '0;
                        asm_q      <= '0;
                        pf_run     <= 1'b0;
                        pf_pending <= 1'b0;
                        state      <= ISSUE;
                    end else if (pf_pending) begin
                        base       <= base + {{(ADDR_W-3){1'b0}}, 3'd4};
                        mem_a      <= base + {{(ADDR_W-3){1'b0}}, 3'd4};
                        cnt        <= '0;
                        asm_q      <= '0;
                        pf_run     <= 1'b1;
                        pf_pending <= 1'b0;
                        state      <= ISSUE;
                    end
`else
                    if (Mc_addr_sgn) begin
                        base  <= req_a;
                        mem_a <= req_a;
                        cnt   <= '0;
                        asm_q <= '0;
                        state <= ISSUE;
                    end
`endif
                end
                ISSUE, DRAIN: begin
                    cnt <= cnt + 3'd1;
                    if (cnt < 3'd3) begin
                        mem_a <= next_a;
                    end
                    if (cnt == 3'd3) begin
                        state <= DRAIN;
                    end
                    if (cap_en) begin
                        case (cap_sel[1:0])
                            2'd0:    asm_q[7:0]   <= mem_din;
                            2'd1:    asm_q[15:8]  <= mem_din;
                            2'd2:    asm_q[23:16] <= mem_din;
                            default: asm_q        <= asm_q;
                        endcase
                    end
                    if (last_cap) begin
`ifdef IMEM_NEXT_WORD_PREFETCH_EN
                        if (pf_run && !pf_same) begin
                            pf_data  <= word;
                            pf_addr  <= base;
                            pf_valid <= 1'b1;
                            pf_run   <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            MC_val     <= word;
                            MC_val_sgn <= 1'b1;
                            pf_run     <= 1'b0;
                            state      <= RESP;
                        end
`else
                        MC_val     <= word;
                        MC_val_sgn <= 1'b1;
                        state      <= RESP;
`endif
                    end
`ifdef IMEM_NEXT_WORD_PREFETCH_EN
                    else if (pf_run && Mc_addr_sgn) begin
                        // same word: prefetch is promoted to the demand fetch; otherwise abandon it
                        pf_run <= 1'b0;
                        if (!pf_same) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end
`endif
                end
                RESP: begin
                    MC_val_sgn <= 1'b0;
                    state      <= IDLE;
`ifdef IMEM_NEXT_WORD_PREFETCH_EN
                    pf_pending <= 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/imem_fetch_port.md
Name: imem_fetch_port

Overview:
Instruction-side responder in the memory controller; the far end of the icache miss interface.
- Accepts a word-fetch request (address plus request level) from icache.
- Issues four pipelined byte reads to the byte-wide unified RAM and assembles a little-endian 32-bit word.
- Returns the word with a one-cycle valid pulse.
- Honours the global rdy stall and the rollback flush.

Parameters:
RAM_LAT, 1, cycles from mem_a presented to matching byte on mem_din; legal values 1 and 2.
ADDR_W, 32, address width of request and RAM ports.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
rdy  in  1  global ready; low freezes every register
rollback  in  1  flush; aborts any fetch in flight
Mc_addr  in  ADDR_W  word address requested by icache (bits[1:0] ignored, treated as 0)
Mc_addr_sgn  in  1  request level; held high while icache misses
MC_val  out  32  assembled instruction word
MC_val_sgn  out  1  one-cycle valid pulse for MC_val
mem_din  in  8  RAM read data
mem_a  out  ADDR_W  RAM byte address
mem_wr  out  1  RAM write enable; constant 0
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async) values: MC_val=0, MC_val_sgn=0, mem_a=0, mem_wr=0, busy=0; state=IDLE; byte counters=0.
- States:
  - IDLE: request sampled.
  - ISSUE: addresses a..a+3 presented.
  - DRAIN: waiting for the last RAM_LAT bytes.
  - RESP: MC_val_sgn high.
- IDLE -> ISSUE at edge E0 when Mc_addr_sgn=1, rollback=0, rdy=1.
  - Latch a = {Mc_addr[ADDR_W-1:2],2'b00}.
  - mem_a = a+k during the cycle after edge E(k), k=0..3.
- Byte capture: byte k is captured at edge E(k+1+RAM_LAT) into MC_val[8k+7:8k]. Byte 0 lands in [7:0].
- ISSUE -> DRAIN after a+3 is issued; DRAIN -> RESP at edge E(4+RAM_LAT), when the last byte is captured.
- RESP: MC_val_sgn=1 for exactly the cycle after E(4+RAM_LAT). Total latency is 5 cycles at RAM_LAT=1.
- RESP -> IDLE unconditionally.
- Mc_addr_sgn is ignored during the RESP cycle; icache deasserts it there anyway. A request is first re-sampled at the edge ending RESP.
- MC_val holds its last value after the pulse. Only MC_val_sgn qualifies it.
- Mc_addr and Mc_addr_sgn are not re-sampled mid-fetch. Address changes during a fetch have no effect.
- rollback=1 at any edge:
  - state becomes IDLE and MC_val_sgn=0 next cycle;
  - partial bytes are discarded;
  - no response is ever produced for the aborted request;
  - rollback takes priority over a simultaneous new request and over completion.
- rdy=0: state, counters, mem_a, MC_val and MC_val_sgn hold. An active MC_val_sgn pulse is extended until the first rdy=1 edge. The bench RAM is gated by the same rdy, so the byte pipeline stays aligned.
- rst asserted mid-fetch: immediate return to reset values; no response.
- Address arithmetic wraps modulo 2^ADDR_W (a=FFFFFFFC reads FFFFFFFC..FFFFFFFF).

Optional Feature:
Macro IMEM_NEXT_WORD_PREFETCH_EN.
- Defined:
  - After each RESP for address a, if no request is pending in IDLE, fetch a+4 into a one-entry buffer (pf_addr, pf_data, pf_valid). busy=1 during the prefetch.
  - A request whose address equals pf_addr with pf_valid=1 returns pf_data with MC_val_sgn in the cycle after E0 (1-cycle hit). The buffer is then consumed and a new prefetch of the next word starts.
  - A request arriving mid-prefetch:
    - same address: becomes the demand fetch and responds on completion;
    - different address: aborts the prefetch and starts the demand fetch at the next edge.
  - rollback kills an in-flight prefetch; a completed pf_valid entry survives.
- Undefined: no buffer; every request takes the full 4+RAM_LAT+1 cycle path.

Test Plan:
- Reset, then RAM[0x100..0x103]=13,05,A0,00 and request 0x100 (RAM_LAT=1) -> MC_val_sgn high for one cycle exactly 5 cycles after sampling edge, MC_val=0x00A00513, mem_wr=0 throughout.
- Request 0x102 -> mem_a sequence 0x100..0x103; same word as 0x100.
- Request 0x200, rollback at E2 -> no MC_val_sgn; busy=0 next cycle; follow-up request 0x100 returns 0x00A00513 with normal latency.
- Request 0x100 with rdy=0 for 3 cycles at E3 -> response delayed by exactly 3 cycles, value unchanged. rdy=0 during RESP -> pulse stretched.
- RAM_LAT=2, request 0xFFFFFFFC -> addresses wrap correctly, response 6 cycles after sampling.
- With IMEM_NEXT_WORD_PREFETCH_EN: request 0x100, idle 6 cycles, request 0x104 -> MC_val_sgn the cycle after sampling with RAM[0x104..0x107].
- With IMEM_NEXT_WORD_PREFETCH_EN: request 0x300 mid-prefetch -> demand fetch of 0x300 with normal latency.
